// File: rtl/superio_irqc.sv
// SuperIO interrupt controller: synchronises up to 8 sources, latches them in edge or
// level mode, and steers masked pending bits onto two registered active-low IRQ lines.
module superio_irqc #(
  parameter int          NSRC = 8,
  parameter logic [7:0]  ID   = 8'h49
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            rw,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic [NSRC-1:0] src,
  output logic [1:0]      irq_n
);

  localparam logic [7:0] VALID = 8'((16'd1 << NSRC) - 16'd1);

  logic [7:0] src_ext;
  logic [7:0] sync1_q, s_q, prev_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] route_q, route_d;
  logic [1:0] irq_n_q, irq_n_d;
  logic [7:0] status, set, clr, edge_next;
  logic [2:0] idx;
  logic       none;
  logic       wr;

  always_comb begin
    src_ext = '0;
    src_ext[NSRC-1:0] = src;
  end

  assign wr     = cs & ~rw;
  assign status = pend_q & mask_q;
  assign none   = (status == 8'h00);

  // Lowest-numbered active STATUS bit wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (status[i]) idx = 3'(i);
    end
  end

  always_comb begin
    mask_d  = (wr && AD == 3'd2) ? (DI & VALID) : mask_q;
    mode_d  = (wr && AD == 3'd3) ? (DI & VALID) : mode_q;
    route_d = (wr && AD == 3'd4) ? (DI & VALID) : route_q;
    set     = mode_q & ((s_q & ~prev_q) | ((wr && AD == 3'd6) ? DI : 8'h00));
    clr     = ((wr && AD == 3'd1) ? DI : 8'h00)
            | ((wr && AD == 3'd5) ? (8'd1 << DI[2:0]) : 8'h00);
    // Set beats clear; the latch only survives while the bit stays edge mode across the edge.
    edge_next = set | (pend_q & ~clr);
    pend_d    = ((mode_d & mode_q & edge_next) | (~mode_d & s_q)) & VALID;
    irq_n_d[0] = ~|(status & ~route_q);
    irq_n_d[1] = ~|(status & route_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 8'h00;
      s_q     <= 8'h00;
      prev_q  <= 8'h00;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      mode_q  <= 8'h00;
      route_q <= 8'h00;
      irq_n_q <= 2'b11;
    end else begin
      sync1_q <= src_ext & VALID;
      s_q     <= sync1_q;
      prev_q  <= s_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      route_q <= route_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

  always_comb begin
    DO = 8'h00;
    if (cs) begin
      case (AD)
        3'd0:    DO = status;
        3'd1:    DO = pend_q;
        3'd2:    DO = mask_q;
        3'd3:    DO = mode_q;
        3'd4:    DO = route_q;
        3'd5:    DO = {none, 4'b0000, idx};
        3'd6:    DO = 8'h00;
        default: DO = ID;
      endcase
    end
  end

endmodule

// File: tb/tb_superio_irqc.sv
// Self-checking bench for superio_irqc: an 8-source instance for the main behaviour and a
// 3-source instance for the narrow-build masking rules.
module tb_superio_irqc;

  logic       clk;
  logic       rst;
  logic       cs, cs3, rw;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO, DO3;
  logic [7:0] src;
  logic [2:0] src3;
  logic [1:0] irq_n, irq_n3;

  logic [7:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] A_STATUS = 3'd0, A_PEND = 3'd1, A_MASK = 3'd2, A_MODE = 3'd3,
                         A_ROUTE = 3'd4, A_VEC = 3'd5, A_SWSET = 3'd6, A_ID = 3'd7;

  superio_irqc #(.NSRC(8), .ID(8'h49)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .AD(AD), .DI(DI), .DO(DO),
    .src(src), .irq_n(irq_n)
  );

  superio_irqc #(.NSRC(3), .ID(8'h49)) dut3 (
    .clk(clk), .rst(rst), .cs(cs3), .rw(rw), .AD(AD), .DI(DI), .DO(DO3),
    .src(src3), .irq_n(irq_n3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input bit sel3, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = 1'b0; AD = a; DI = d;
    if (sel3) cs3 = 1'b1; else cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0; cs3 = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input bit sel3, input logic [2:0] a,
                        input logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    rw = 1'b1; AD = a;
    if (sel3) cs3 = 1'b1; else cs = 1'b1;
    #1;
    got = sel3 ? DO3 : DO;
    cs = 1'b0; cs3 = 1'b0;
    check(tag, got, exp_q.pop_front());
  endtask

  task automatic irq_chk(input string tag, input logic [1:0] exp);
    exp_q.push_back({6'b0, exp});
    check(tag, {6'b0, irq_n}, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; cs3 = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
    src = 8'hFF; src3 = 3'b000;

    // Reset held with all sources high
    wait_edges(3);
    irq_chk("rst_irq", 2'b11);
    rd_chk("rst_mask",  1'b0, A_MASK,  8'h00);
    rd_chk("rst_mode",  1'b0, A_MODE,  8'h00);
    rd_chk("rst_route", 1'b0, A_ROUTE, 8'h00);
    rd_chk("rst_id",    1'b0, A_ID,    8'h49);
    rd_chk("rst_vec",   1'b0, A_VEC,   8'h80);
    check("rst_irq3", {6'b0, irq_n3}, 8'h03);
    @(negedge clk);
    src = 8'h00; rst = 1'b1;
    wait_edges(3);
    irq_chk("post_rst_irq", 2'b11);

    // Edge latch on source 2
    wr_reg(1'b0, A_MODE, 8'h04);
    wr_reg(1'b0, A_MASK, 8'h04);
    @(negedge clk); src = 8'h04;
    @(posedge clk);
    @(negedge clk); src = 8'h00;
    wait_edges(2);
    irq_chk("edge_k2", 2'b11);
    wait_edges(1);
    irq_chk("edge_k3", 2'b10);
    wait_edges(3);
    irq_chk("edge_hold", 2'b10);
    rd_chk("edge_status", 1'b0, A_STATUS, 8'h04);
    rd_chk("edge_vec",    1'b0, A_VEC,    8'h02);
    wr_reg(1'b0, A_VEC, 8'h02);
    irq_chk("ack_same_edge", 2'b10);
    wait_edges(1);
    irq_chk("ack_next_edge", 2'b11);
    rd_chk("ack_pend", 1'b0, A_PEND, 8'h00);

    // Level mode with routing
    wr_reg(1'b0, A_MODE,  8'h00);
    wr_reg(1'b0, A_MASK,  8'h81);
    wr_reg(1'b0, A_ROUTE, 8'h80);
    @(negedge clk); src = 8'h80;
    wait_edges(3);
    irq_chk("lvl7_k2", 2'b11);
    wait_edges(1);
    irq_chk("lvl7_k3", 2'b01);
    @(negedge clk); src = 8'h81;
    wait_edges(4);
    irq_chk("lvl_both", 2'b00);
    rd_chk("lvl_vec", 1'b0, A_VEC, 8'h00);
    wr_reg(1'b0, A_PEND, 8'h81);
    wait_edges(1);
    rd_chk("lvl_w1c_pend", 1'b0, A_PEND, 8'h81);
    irq_chk("lvl_w1c_irq", 2'b00);
    @(negedge clk); src = 8'h00;
    wait_edges(3);
    irq_chk("lvl_drop_k2", 2'b00);
    wait_edges(1);
    irq_chk("lvl_drop_k3", 2'b11);

    // Set/clear collision on source 1
    wr_reg(1'b0, A_MASK,  8'h00);
    wr_reg(1'b0, A_MODE,  8'h02);
    wr_reg(1'b0, A_SWSET, 8'h02);
    rd_chk("coll_pre", 1'b0, A_PEND, 8'h02);
    @(negedge clk); src = 8'h02;
    @(posedge clk);
    @(posedge clk);
    wr_reg(1'b0, A_PEND, 8'h02);
    rd_chk("coll_setwins", 1'b0, A_PEND, 8'h02);
    wr_reg(1'b0, A_PEND, 8'h02);
    rd_chk("w1c_clears", 1'b0, A_PEND, 8'h00);
    @(negedge clk); src = 8'h00;
    wait_edges(3);

    // Software set
    wr_reg(1'b0, A_MODE,  8'h0F);
    wr_reg(1'b0, A_SWSET, 8'hFF);
    rd_chk("sw_pend",  1'b0, A_PEND,  8'h0F);
    rd_chk("sw_read0", 1'b0, A_SWSET, 8'h00);
    wr_reg(1'b0, A_MASK, 8'h08);
    rd_chk("sw_vec", 1'b0, A_VEC, 8'h03);
    wait_edges(1);
    irq_chk("sw_irq", 2'b10);

    // Reset drops a pending interrupt
    @(negedge clk); rst = 1'b0;
    wait_edges(1);
    irq_chk("rst_drop_irq", 2'b11);
    rd_chk("rst_drop_mask", 1'b0, A_MASK, 8'h00);
    rd_chk("rst_drop_pend", 1'b0, A_PEND, 8'h00);
    @(negedge clk); rst = 1'b1;
    wait_edges(2);
    irq_chk("rst_release", 2'b11);

    // Three-source build
    wr_reg(1'b1, A_MASK, 8'hFF);
    rd_chk("n3_mask", 1'b1, A_MASK, 8'h07);
    wr_reg(1'b1, A_MODE, 8'hFF);
    rd_chk("n3_mode", 1'b1, A_MODE, 8'h07);
    wr_reg(1'b1, A_SWSET, 8'hFF);
    rd_chk("n3_pend", 1'b1, A_PEND, 8'h07);
    wr_reg(1'b1, A_VEC, 8'h05);
    rd_chk("n3_vec5", 1'b1, A_PEND, 8'h07);
    wr_reg(1'b1, A_VEC, 8'h01);
    rd_chk("n3_vec1", 1'b1, A_PEND, 8'h05);
    rd_chk("n3_id",   1'b1, A_ID,   8'h49);
    wait_edges(1);
    check("n3_irq", {6'b0, irq_n3}, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
